data_memory_arbiter: RTL
========================

// Module: data_memory_arbiter
// PURPOSE
//  Shares a single data-memory access port between the execute stage and the debug/loader port.
//  Requests are captured, arbitrated round-robin, issued to memory, and read data is returned with a valid pulse.
//  Sits between execution / debug logic and one rd/wr port pair of TheDataMemory.
//  Only one access is in flight at a time; the requester holds its request until granted.
// PARAMETERS
//  ADDR_WIDTH    9   data memory word address width
//  DATA_WIDTH    32  data memory word width
//  RD_LATENCY    1   cycles from mem_rd_addr valid to mem_rd_data valid (1..7)
// PORTS
//  clock          in   1           system clock, rising edge
//  reset          in   1           asynchronous, active-high reset
//  exec_req       in   1           execute stage requests an access
//  exec_we        in   1           1 = write, 0 = read
//  exec_addr      in   ADDR_WIDTH  execute access address
//  exec_wdata     in   DATA_WIDTH  execute write data
//  exec_gnt       out  1           one-cycle pulse: execute request accepted
//  exec_rvalid    out  1           one-cycle pulse: exec_rdata valid
//  exec_rdata     out  DATA_WIDTH  read data returned to execute
//  dbg_req/dbg_we/dbg_addr/dbg_wdata  in  1/1/ADDR_WIDTH/DATA_WIDTH  debug port request, same meaning
//  dbg_gnt/dbg_rvalid/dbg_rdata  out  1/1/DATA_WIDTH  debug port responses, same meaning
//  mem_rd_addr    out  ADDR_WIDTH  memory read address
//  mem_wr_addr    out  ADDR_WIDTH  memory write address
//  mem_wr_data    out  DATA_WIDTH  memory write data
//  mem_wr_enable  out  1           memory write strobe
//  mem_rd_data    in   DATA_WIDTH  memory read data
//  busy           out  1           1 when state != IDLE
// BEHAVIOUR
//  Reset (async, active-high): state=IDLE; every output 0; rr_ptr=EXEC (exec wins the first tie); latency counter=0.
//  FSM states: IDLE, ISSUE, WAIT, RESP.
//  IDLE: if any req is high at a clock edge, capture the winner's we/addr/wdata/id and go to ISSUE.
//   Both requests high: winner=rr_ptr, and rr_ptr flips to the other requester.
//   One request high: that requester wins, and rr_ptr points to the other requester.
//  ISSUE (1 cycle): the winner's gnt=1; mem addr/data are driven from the captured request.
//   Write: mem_wr_enable=1 this cycle only, then go to IDLE.
//   Read: mem_rd_addr is held until RESP ends. If RD_LATENCY==1 go to RESP, else go to WAIT.
//  WAIT: count RD_LATENCY-1 cycles, then go to RESP.
//  RESP (1 cycle): the winner's rvalid=1 and rdata=mem_rd_data; then go to IDLE.
//   rdata is registered and holds its value until the next rvalid for that port.
//  Latency from req edge to gnt: 1 cycle. Write throughput: 1 write per 2 cycles.
//  Read: rvalid comes RD_LATENCY+1 cycles after gnt.
//  Requests are sampled only in IDLE; req, addr and data may change freely after gnt.
//   A req dropped before gnt is simply not served.
//  A req still high in the RESP or final write cycle is considered in the next IDLE. No back-to-back grant without IDLE.
//  Never both gnt high; never both rvalid high; mem_wr_enable is never high outside ISSUE.
//  Address/data are passed unmodified (no width conversion); out-of-range behaviour is TheDataMemory's.
//  Reset mid-operation: the in-flight read is dropped (no rvalid); a write in its ISSUE cycle is not guaranteed to complete.
// TESTING
//  1. exec_req=1, we=1, addr=0x005, wdata=0xDEADBEEF -> next cycle exec_gnt=1, mem_wr_enable=1, mem_wr_addr=0x005; memory word 5 reads back 0xDEADBEEF.
//  2. exec_req and dbg_req both held high for 8 cycles, all writes -> grants alternate exec, dbg, exec, dbg; each gnt is 2 cycles apart.
//  3. RD_LATENCY=3, dbg read at addr 0x010 holding 0x12345678 -> dbg_gnt at T+1, dbg_rvalid at T+5, dbg_rdata=0x12345678, exec_rvalid=0.
//  4. Exec read issued, reset pulsed during WAIT -> all outputs 0 immediately, no rvalid afterwards, busy=0; next exec_req wins the first tie.
//  5. Exec read then exec write to the same address back to back -> read returns the old value and the write lands; no overlapping mem strobes.
//  6. dbg_req pulsed for 1 cycle while exec is in ISSUE -> dbg never granted, no mem access; busy returns to 0.

Source files
------------

// File: rtl/data_memory_arbiter.sv
// Shares one data-memory rd/wr port pair between the execute stage and the debug/loader port.
// Round-robin arbitration, one access in flight, registered read-data return with a valid pulse.
module data_memory_arbiter #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  exec_req,
  input  logic                  exec_we,
  input  logic [ADDR_WIDTH-1:0] exec_addr,
  input  logic [DATA_WIDTH-1:0] exec_wdata,
  output logic                  exec_gnt,
  output logic                  exec_rvalid,
  output logic [DATA_WIDTH-1:0] exec_rdata,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  mem_wr_enable,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  busy,
  output logic [1:0]            fsm_state
);

  // Handshake: a requester holds req until it sees a one-cycle gnt; requests are
  // sampled only in IDLE, so req/addr/data may change freely from the gnt cycle on.
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  localparam logic [2:0] WAIT_LAST = 3'(RD_LATENCY > 1 ? RD_LATENCY - 2 : 0);

  state_t                state, state_nx;
  logic                  rr_ptr;     // 0 = exec, 1 = dbg
  logic                  winner;
  logic                  cur_id;
  logic                  cur_we;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH-1:0] cur_wdata;
  logic [2:0]            wait_cnt;

  always_comb begin
    winner = 1'b0;
    if (exec_req && dbg_req) winner = rr_ptr;
    else if (dbg_req)        winner = 1'b1;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (exec_req || dbg_req) state_nx = ISSUE;
      ISSUE: begin
        if (cur_we)               state_nx = IDLE;
        else if (RD_LATENCY == 1) state_nx = RESP;
        else                      state_nx = WAIT;
      end
      WAIT:    if (wait_cnt == WAIT_LAST) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    exec_gnt      = (state == ISSUE) && !cur_id;
    dbg_gnt       = (state == ISSUE) &&  cur_id;
    mem_wr_enable = (state == ISSUE) &&  cur_we;
    mem_wr_addr   = mem_wr_enable ? cur_addr  : '0;
    mem_wr_data   = mem_wr_enable ? cur_wdata : '0;
    // Read address stays on the port from ISSUE through RESP.
    mem_rd_addr   = (state != IDLE && !cur_we) ? cur_addr : '0;
    busy          = (state != IDLE);
    fsm_state     = state;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr    <= 1'b0;
      cur_id    <= 1'b0;
      cur_we    <= 1'b0;
      cur_addr  <= '0;
      cur_wdata <= '0;
    end else if (state == IDLE && (exec_req || dbg_req)) begin
      rr_ptr    <= ~winner;
      cur_id    <= winner;
      cur_we    <= winner ? dbg_we    : exec_we;
      cur_addr  <= winner ? dbg_addr  : exec_addr;
      cur_wdata <= winner ? dbg_wdata : exec_wdata;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                wait_cnt <= 3'd0;
    else if (state == ISSUE)  wait_cnt <= 3'd0;
    else if (state == WAIT)   wait_cnt <= wait_cnt + 3'd1;
  end

  // Read data is sampled at the end of RESP and held until that port's next read.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      exec_rvalid <= 1'b0;
      dbg_rvalid  <= 1'b0;
      exec_rdata  <= '0;
      dbg_rdata   <= '0;
    end else begin
      exec_rvalid <= (state == RESP) && !cur_id;
      dbg_rvalid  <= (state == RESP) &&  cur_id;
      if (state == RESP && !cur_id) exec_rdata <= mem_rd_data;
      if (state == RESP &&  cur_id) dbg_rdata  <= mem_rd_data;
    end
  end

endmodule
